// File: rtl/fp_normalize_pack_if.sv
`default_nettype none
// ============================================================================
// Module      : fp_normalize_pack_if
// Description : Handshake and data bundle between the MAC accumulate stage,
//               the normalize/pack back end and the result consumer.
//               slave  - seen from fp_normalize_pack (accepts operands,
//                        produces results)
//               master - seen from the producer/consumer side
// Signals     : in_valid/in_ready   operand handshake
//               in_sign, in_exp[9:0], in_mant[47:0]   operand fields
//               out_valid/out_ready result handshake
//               out_result[31:0], out_overflow, out_underflow
// Revision    : 1.0 - initial release
// ============================================================================
interface fp_normalize_pack_if;
   logic        in_valid;
   logic        in_ready;
   logic        in_sign;
   logic [9:0]  in_exp;
   logic [47:0] in_mant;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic        out_overflow;
   logic        out_underflow;

   modport slave (
      input  in_valid, in_sign, in_exp, in_mant, out_ready,
      output in_ready, out_valid, out_result, out_overflow, out_underflow
   );

   modport master (
      output in_valid, in_sign, in_exp, in_mant, out_ready,
      input  in_ready, out_valid, out_result, out_overflow, out_underflow
   );
endinterface
`default_nettype wire

// File: rtl/fp_normalize_pack.sv
`default_nettype none
// ============================================================================
// Module      : fp_normalize_pack
// Description : Floating-point MAC result back end. Normalizes a 48-bit
//               unnormalized significand one bit per cycle, rounds to
//               nearest-even and packs an IEEE-754 single-precision word.
//               Overflow saturates to infinity, underflow flushes to zero.
// Ports       : clk  - rising-edge clock
//               rst  - synchronous active-high reset
//               bus  - fp_normalize_pack_if.slave (operand in, result out)
// Revision    : 1.0 - initial release
// ============================================================================
module fp_normalize_pack (
   input  wire logic          clk,
   input  wire logic          rst,
   fp_normalize_pack_if.slave bus
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_NORM  = 2'd1;
   localparam logic [1:0] S_ROUND = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]         r_state;
   logic [1:0]         w_state_nxt;

   logic               r_sign;
   logic signed [10:0] r_exp;
   logic [47:0]        r_mant;
   logic               r_sticky;
   logic [31:0]        r_result;
   logic               r_ovf;
   logic               r_unf;

   // Significand binary point sits between bits 46 and 45; bit 47 is the
   // single possible carry bit from the accumulator.
   logic               w_mant_zero;
   logic               w_need_rshift;
   logic               w_need_lshift;

   logic               w_guard;
   logic               w_sticky_all;
   logic               w_round_up;
   logic               w_carry;
   logic [22:0]        w_frac_rnd;
   logic signed [10:0] w_exp_rnd;
   logic               w_ovf;
   logic               w_unf;
   logic [31:0]        w_pack;

   assign w_mant_zero   = (r_mant == 48'h0);
   assign w_need_rshift = r_mant[47];
   assign w_need_lshift = ~r_mant[46];

   // In ROUND bit 46 is always the hidden one, so the 24-bit keep field only
   // carries out when the 23 fraction bits are all ones and we round up. The
   // 23-bit sum then wraps to zero, which is exactly the 1.000.. fraction.
   assign w_guard      = r_mant[22];
   assign w_sticky_all = r_sticky | (|r_mant[21:0]);
   assign w_round_up   = w_guard & (w_sticky_all | r_mant[23]);
   assign w_carry      = w_round_up & (&r_mant[45:23]);
   assign w_frac_rnd   = r_mant[45:23] + {22'h0, w_round_up};
   assign w_exp_rnd    = r_exp + $signed({10'h0, w_carry});

   assign w_ovf = (w_exp_rnd >= 11'sd255);
   assign w_unf = (w_exp_rnd <= 11'sd0);

   always_comb begin
      w_pack = {r_sign, w_exp_rnd[7:0], w_frac_rnd};
      if (w_ovf) begin
         w_pack = {r_sign, 8'hFF, 23'h0};
      end else if (w_unf) begin
         w_pack = {r_sign, 31'h0};
      end
   end

   // ---------------------------------------------------------------- state
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (bus.in_valid) begin
               w_state_nxt = S_NORM;
            end
         end
         S_NORM: begin
            if (w_mant_zero) begin
               w_state_nxt = S_DONE;
            end else if (!w_need_rshift && !w_need_lshift) begin
               w_state_nxt = S_ROUND;
            end
         end
         S_ROUND: begin
            w_state_nxt = S_DONE;
         end
         S_DONE: begin
            if (bus.out_ready) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_comb begin
      bus.in_ready      = (r_state == S_IDLE);
      bus.out_valid     = (r_state == S_DONE);
      bus.out_result    = r_result;
      bus.out_overflow  = r_ovf;
      bus.out_underflow = r_unf;
   end

   // ------------------------------------------------------------- datapath
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sign   <= 1'b0;
         r_exp    <= 11'sd0;
         r_mant   <= 48'h0;
         r_sticky <= 1'b0;
         r_result <= 32'h0;
         r_ovf    <= 1'b0;
         r_unf    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.in_valid) begin
                  r_sign   <= bus.in_sign;
                  r_exp    <= {bus.in_exp[9], bus.in_exp};
                  r_mant   <= bus.in_mant;
                  r_sticky <= 1'b0;
               end
            end
            S_NORM: begin
               if (w_mant_zero) begin
                  r_result <= {r_sign, 31'h0};
                  r_ovf    <= 1'b0;
                  r_unf    <= 1'b0;
               end else if (w_need_rshift) begin
                  r_mant   <= {1'b0, r_mant[47:1]};
                  r_sticky <= r_sticky | r_mant[0];
                  r_exp    <= r_exp + 11'sd1;
               end else if (w_need_lshift) begin
                  r_mant <= {r_mant[46:0], 1'b0};
                  r_exp  <= r_exp - 11'sd1;
               end
            end
            S_ROUND: begin
               r_result <= w_pack;
               r_ovf    <= w_ovf;
               r_unf    <= w_unf & ~w_ovf;
            end
            default: begin
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fp_normalize_pack.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_normalize_pack
// Description : Self-checking bench for fp_normalize_pack: directed vector
//               table, handshake-hold and mid-operation reset sequences, and
//               randomized operands checked against a value-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_normalize_pack;

   typedef struct {
      logic        s;
      logic [9:0]  e;
      logic [47:0] m;
      logic [31:0] res;
      logic        ovf;
      logic        unf;
      int          lat;
   } vec_t;

   typedef struct {
      logic [31:0] res;
      logic        ovf;
      logic        unf;
      int          lat;
   } model_t;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_err;

   fp_normalize_pack_if bif();

   fp_normalize_pack u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   // Reference: locate the leading one, take 24 bits below it, round the
   // remainder to nearest-even, then range-check the resulting exponent.
   function automatic model_t model(input logic s, input logic [9:0] e, input logic [47:0] m);
      model_t     r;
      int         p;
      int         ex;
      int         sh;
      logic [63:0] mm;
      logic [63:0] keep;
      logic        guard;
      logic        sticky;
      r.ovf = 1'b0;
      r.unf = 1'b0;
      if (m == 48'h0) begin
         r.res = {s, 31'h0};
         r.lat = 2;
         return r;
      end
      p = 0;
      for (int i = 0; i < 48; i++) if (m[i]) p = i;
      ex = int'($signed(e)) + p - 46;
      r.lat = ((p >= 46) ? (p - 46) : (46 - p)) + 3;
      mm = {16'h0, m};
      if (p >= 24) begin
         sh     = p - 23;
         keep   = mm >> sh;
         guard  = mm[sh-1];
         sticky = ((mm & ((64'd1 << (sh - 1)) - 64'd1)) != 64'd0);
      end else begin
         keep   = mm << (23 - p);
         guard  = 1'b0;
         sticky = 1'b0;
      end
      if (guard && (sticky || keep[0])) keep = keep + 64'd1;
      if (keep == 64'h100_0000) begin
         keep = 64'h80_0000;
         ex   = ex + 1;
      end
      if (ex >= 255) begin
         r.res = {s, 8'hFF, 23'h0};
         r.ovf = 1'b1;
      end else if (ex <= 0) begin
         r.res = {s, 31'h0};
         r.unf = 1'b1;
      end else begin
         r.res = {s, ex[7:0], keep[22:0]};
      end
      return r;
   endfunction

   // Start at #1 after an edge. Returns the edge number (acceptance = 1)
   // after which out_valid was first seen, or -1 on timeout.
   task automatic start_op(input logic s, input logic [9:0] e, input logic [47:0] m, output int lat);
      int n;
      n = 0;
      while (!bif.in_ready && n < 100) begin
         @(posedge clk); #1; n++;
      end
      bif.in_sign  = s;
      bif.in_exp   = e;
      bif.in_mant  = m;
      bif.in_valid = 1'b1;
      @(posedge clk); #1;
      bif.in_valid = 1'b0;
      bif.in_sign  = 1'($urandom);
      bif.in_exp   = 10'($urandom);
      bif.in_mant  = {16'($urandom), 32'($urandom)};
      n = 1;
      while (!bif.out_valid && n < 200) begin
         @(posedge clk); #1; n++;
      end
      lat = bif.out_valid ? n : -1;
   endtask

   task automatic consume();
      bif.out_ready = 1'b1;
      @(posedge clk); #1;
      bif.out_ready = 1'b0;
   endtask

   task automatic run_op(input string tag, input logic s, input logic [9:0] e, input logic [47:0] m,
                         input logic [31:0] res, input logic ovf, input logic unf, input int lat);
      int got_lat;
      start_op(s, e, m, got_lat);
      check({tag, "_lat"}, 64'(got_lat), 64'(lat));
      check({tag, "_res"}, 64'(bif.out_result), 64'(res));
      check({tag, "_ovf"}, 64'(bif.out_overflow), 64'(ovf));
      check({tag, "_unf"}, 64'(bif.out_underflow), 64'(unf));
      consume();
   endtask

   vec_t   vecs[15];
   model_t mr;

   initial begin
      logic [31:0] hold_res;
      logic        hold_ovf;
      logic        hold_unf;
      int          lat;
      logic        rs;
      logic [9:0]  re;
      logic [47:0] rm;

      n_cmp = 0;
      n_err = 0;
      rst           = 1'b1;
      bif.in_valid  = 1'b0;
      bif.in_sign   = 1'b0;
      bif.in_exp    = 10'h0;
      bif.in_mant   = 48'h0;
      bif.out_ready = 1'b0;

      vecs[0]  = '{1'b0, 10'd127, 48'h1 << 46,                           32'h3F800000, 1'b0, 1'b0, 3};
      vecs[1]  = '{1'b0, 10'd127, 48'h3 << 46,                           32'h40400000, 1'b0, 1'b0, 4};
      vecs[2]  = '{1'b0, 10'd127, 48'h1 << 40,                           32'h3C800000, 1'b0, 1'b0, 9};
      vecs[3]  = '{1'b1, 10'd127, (48'h1 << 46) | (48'h1 << 22),         32'hBF800000, 1'b0, 1'b0, 3};
      vecs[4]  = '{1'b0, 10'd127, (48'h1 << 46) | (48'h3 << 22),         32'h3F800002, 1'b0, 1'b0, 3};
      vecs[5]  = '{1'b0, 10'd254, 48'h7FFF_FFFF_FFFF,                    32'h7F800000, 1'b1, 1'b0, 3};
      vecs[6]  = '{1'b0, 10'd1,   48'h1 << 45,                           32'h00000000, 1'b0, 1'b1, 4};
      vecs[7]  = '{1'b1, 10'd127, 48'h0,                                 32'h80000000, 1'b0, 1'b0, 2};
      vecs[8]  = '{1'b0, 10'd127, 48'h1,                                 32'h28800000, 1'b0, 1'b0, 49};
      vecs[9]  = '{1'b0, 10'd127, (48'h1 << 47) | (48'h1 << 23) | 48'h1, 32'h40000001, 1'b0, 1'b0, 4};
      vecs[10] = '{1'b0, 10'd127, (48'h1 << 47) | (48'h1 << 23),         32'h40000000, 1'b0, 1'b0, 4};
      vecs[11] = '{1'b1, 10'h3FB, 48'h1 << 46,                           32'h80000000, 1'b0, 1'b1, 3};
      vecs[12] = '{1'b0, 10'd254, 48'h1 << 46,                           32'h7F000000, 1'b0, 1'b0, 3};
      vecs[13] = '{1'b0, 10'd1,   48'h1 << 46,                           32'h00800000, 1'b0, 1'b0, 3};
      vecs[14] = '{1'b0, 10'd254, 48'h1 << 47,                           32'h7F800000, 1'b1, 1'b0, 4};

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check("rst_in_ready",  64'(bif.in_ready), 64'd1);
      check("rst_out_valid", 64'(bif.out_valid), 64'd0);
      check("rst_result",    64'(bif.out_result), 64'd0);
      check("rst_flags",     64'({bif.out_overflow, bif.out_underflow}), 64'd0);

      for (int i = 0; i < 15; i++) begin
         run_op($sformatf("vec%0d", i), vecs[i].s, vecs[i].e, vecs[i].m,
                vecs[i].res, vecs[i].ovf, vecs[i].unf, vecs[i].lat);
      end

      // Back-pressure: result must stay put while the consumer stalls.
      start_op(1'b0, 10'd127, 48'h3 << 46, lat);
      check("hold_lat", 64'(lat), 64'd4);
      hold_res = bif.out_result;
      hold_ovf = bif.out_overflow;
      hold_unf = bif.out_underflow;
      check("hold_res0", 64'(hold_res), 64'h40400000);
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         check($sformatf("hold_res_c%0d", c),   64'(bif.out_result), 64'(hold_res));
         check($sformatf("hold_flags_c%0d", c), 64'({bif.out_overflow, bif.out_underflow}), 64'({hold_ovf, hold_unf}));
         check($sformatf("hold_valid_c%0d", c), 64'(bif.out_valid), 64'd1);
         check($sformatf("hold_ready_c%0d", c), 64'(bif.in_ready), 64'd0);
      end
      consume();
      check("release_in_ready",  64'(bif.in_ready), 64'd1);
      check("release_out_valid", 64'(bif.out_valid), 64'd0);

      // Reset in the middle of a long left-shift normalization.
      bif.in_sign  = 1'b1;
      bif.in_exp   = 10'd127;
      bif.in_mant  = 48'h1;
      bif.in_valid = 1'b1;
      @(posedge clk); #1;
      bif.in_valid = 1'b0;
      check("norm_in_ready", 64'(bif.in_ready), 64'd0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("midrst_out_valid", 64'(bif.out_valid), 64'd0);
      check("midrst_in_ready",  64'(bif.in_ready), 64'd1);
      check("midrst_result",    64'(bif.out_result), 64'd0);
      check("midrst_flags",     64'({bif.out_overflow, bif.out_underflow}), 64'd0);
      run_op("after_rst", 1'b0, 10'd127, 48'h1 << 40, 32'h3C800000, 1'b0, 1'b0, 9);

      // Randomized operands: leading one spread over the whole significand.
      for (int i = 0; i < 300; i++) begin
         rs = 1'($urandom);
         rm = {16'($urandom), 32'($urandom)} >> $urandom_range(0, 47);
         if ($urandom_range(0, 9) == 0) rm = 48'h0;
         if ($urandom_range(0, 3) == 0) re = 10'($urandom);
         else                           re = 10'($urandom_range(0, 300));
         mr = model(rs, re, rm);
         run_op($sformatf("rnd%0d", i), rs, re, rm, mr.res, mr.ovf, mr.unf, mr.lat);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
